divider_pipe_ctrl: RTL and testbench

//  Parametrised iterative restoring divider with valid/ready handshakes on input and output.

---
 rtl/divider_pipe_ctrl_pkg.sv | 27 ++
 rtl/divider_pipe_ctrl_step.sv | 21 ++
 rtl/divider_pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_divider_pipe_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pipe_ctrl_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and sizing helpers.
package div_defs;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } div_state_t;

   function automatic int clog2(input int value);
      int v;
      int r;
      v = value - 1;
      r = 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int iter_count(input int width, input int bpc);
      return width / bpc;
   endfunction

endpackage

// File: rtl/divider_pipe_ctrl_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Trial difference is one bit wider than the accumulator so its sign is the quotient bit.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   i_rem,
   input  logic [WIDTH-1:0] i_div,
   input  logic             i_bit,
   output logic [WIDTH:0]   o_rem,
   output logic             o_q
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;

   assign w_shift = {i_rem, i_bit};
   assign w_diff  = w_shift - {2'b00, i_div};
   assign o_q     = ~w_diff[WIDTH+1];
   assign o_rem   = o_q ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/divider_pipe_ctrl.sv
// Iterative restoring divider, BPC quotient bits per cycle, signed/unsigned, valid/ready both sides.
// Result valid WIDTH/BPC+2 cycles after accept (1 for divide-by-zero); result held until out_ready.
module divider_pipe_ctrl
   import div_defs::*;
#(
   parameter int WIDTH = 16,
   parameter int BPC   = 1,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             sign,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow,
   output logic [TAG_W-1:0] out_tag
);

   localparam int ITER  = iter_count(WIDTH, BPC);
   localparam int CNT_W = clog2(ITER + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   div_state_t r_state, w_next_state;

   logic [CNT_W-1:0]  r_cnt;
   logic [WIDTH-1:0]  r_dvd;      // dividend magnitude; quotient bits shift in from the bottom
   logic [WIDTH-1:0]  r_dsr;
   logic [WIDTH:0]    r_rem;
   logic              r_q_neg;
   logic              r_r_neg;
   logic              r_ovf_pend;
   logic [TAG_W-1:0]  r_tag;
   logic [WIDTH-1:0]  r_quot;
   logic [WIDTH-1:0]  r_rem_out;
   logic              r_dz;
   logic              r_ovf;
   logic [TAG_W-1:0]  r_out_tag;

   logic              w_accept;
   logic              w_div_zero;
   logic [WIDTH-1:0]  w_dvd_mag;
   logic [WIDTH-1:0]  w_dsr_mag;
   logic [BPC:0][WIDTH:0] w_rem_chain;
   logic [BPC-1:0]    w_qbits;
   logic [WIDTH-1:0]  w_dvd_shift;
   logic [WIDTH-1:0]  w_q_fix;
   logic [WIDTH-1:0]  w_r_fix;

   assign in_ready   = (r_state == S_IDLE) & ~reset;
   assign out_valid  = (r_state == S_DONE) & ~reset;
   assign w_accept   = in_valid & in_ready;
   assign w_div_zero = (divisor == '0);

   assign w_dvd_mag = (sign & dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
   assign w_dsr_mag = (sign & divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

   assign w_rem_chain[0] = r_rem;

   for (genvar gi = 0; gi < BPC; gi++) begin : g_step
      div_step #(.WIDTH(WIDTH)) u_step (
         .i_rem (w_rem_chain[gi]),
         .i_div (r_dsr),
         .i_bit (r_dvd[WIDTH-1-gi]),
         .o_rem (w_rem_chain[gi+1]),
         .o_q   (w_qbits[BPC-1-gi])
      );
   end

   assign w_dvd_shift = (r_dvd << BPC) | WIDTH'(w_qbits);
   assign w_q_fix     = r_q_neg ? (~r_dvd + WIDTH'(1)) : r_dvd;
   assign w_r_fix     = r_r_neg ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = w_div_zero ? S_DONE : S_CALC;
         S_CALC:  if (r_cnt == CNT_W'(1)) w_next_state = S_FIXUP;
         S_FIXUP: w_next_state = S_DONE;
         S_DONE:  if (out_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_dsr      <= '0;
         r_rem      <= '0;
         r_q_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
         r_ovf_pend <= 1'b0;
         r_tag      <= '0;
         r_quot     <= '0;
         r_rem_out  <= '0;
         r_dz       <= 1'b0;
         r_ovf      <= 1'b0;
         r_out_tag  <= '0;
      end else begin
         if (w_accept) begin
            r_dvd      <= w_dvd_mag;
            r_dsr      <= w_dsr_mag;
            r_rem      <= '0;
            r_cnt      <= CNT_INIT;
            r_q_neg    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_r_neg    <= sign & dividend[WIDTH-1];
            r_ovf_pend <= sign & (dividend == MIN_VAL) & (divisor == '1);
            r_tag      <= in_tag;
            r_dz       <= w_div_zero;
            r_ovf      <= 1'b0;
            // Zero divisor skips the datapath; the raw dividend is reported as remainder.
            if (w_div_zero) begin
               r_quot    <= '1;
               r_rem_out <= dividend;
               r_out_tag <= in_tag;
            end
         end
         if (r_state == S_CALC) begin
            r_rem <= w_rem_chain[BPC];
            r_dvd <= w_dvd_shift;
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (r_state == S_FIXUP) begin
            r_quot    <= w_q_fix;
            r_rem_out <= w_r_fix;
            r_ovf     <= r_ovf_pend;
            r_out_tag <= r_tag;
         end
      end
   end

   assign quotient    = r_quot;
   assign remainder   = r_rem_out;
   assign div_by_zero = r_dz;
   assign overflow    = r_ovf;
   assign out_tag     = r_out_tag;

endmodule

// File: tb/tb_divider_pipe_ctrl.sv
// Bench for two divider configurations (8-bit/BPC1 and 16-bit/BPC2) against an arithmetic model.
module tb_divider_pipe_ctrl;

   logic clk;
   logic reset;

   logic       a_in_valid, a_in_ready, a_sign, a_out_valid, a_out_ready, a_dz, a_ov;
   logic [7:0] a_dividend, a_divisor, a_quotient, a_remainder;
   logic [3:0] a_in_tag, a_out_tag;

   logic        b_in_valid, b_in_ready, b_sign, b_out_valid, b_out_ready, b_dz, b_ov;
   logic [15:0] b_dividend, b_divisor, b_quotient, b_remainder;
   logic [3:0]  b_in_tag, b_out_tag;

   divider_pipe_ctrl #(.WIDTH(8), .BPC(1), .TAG_W(4)) u_dut_a (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .dividend(a_dividend), .divisor(a_divisor), .sign(a_sign), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .quotient(a_quotient), .remainder(a_remainder),
      .div_by_zero(a_dz), .overflow(a_ov), .out_tag(a_out_tag)
   );

   divider_pipe_ctrl #(.WIDTH(16), .BPC(2), .TAG_W(4)) u_dut_b (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .dividend(b_dividend), .divisor(b_divisor), .sign(b_sign), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .quotient(b_quotient), .remainder(b_remainder),
      .div_by_zero(b_dz), .overflow(b_ov), .out_tag(b_out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int sel   = 0;

   logic        cur_in_ready, cur_out_valid, cur_dz, cur_ov;
   logic [15:0] cur_q, cur_r;
   logic [3:0]  cur_tag;

   always_comb begin
      if (sel == 0) begin
         cur_in_ready  = a_in_ready;
         cur_out_valid = a_out_valid;
         cur_dz        = a_dz;
         cur_ov        = a_ov;
         cur_q         = {8'h00, a_quotient};
         cur_r         = {8'h00, a_remainder};
         cur_tag       = a_out_tag;
      end else begin
         cur_in_ready  = b_in_ready;
         cur_out_valid = b_out_valid;
         cur_dz        = b_dz;
         cur_ov        = b_ov;
         cur_q         = b_quotient;
         cur_r         = b_remainder;
         cur_tag       = b_out_tag;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // C-style truncating division on w-bit operands, with the divider's flag rules.
   function automatic void ref_div(input int w, input logic [15:0] dvd, input logic [15:0] dsr,
                                   input logic sg, output logic [15:0] q, output logic [15:0] r,
                                   output logic dz, output logic ov);
      longint a, b, mask, minv;
      mask = (longint'(1) << w) - 1;
      minv = longint'(1) << (w - 1);
      dz = 1'b0;
      ov = 1'b0;
      if (dsr == 16'h0) begin
         q  = 16'(mask);
         r  = dvd;
         dz = 1'b1;
      end else begin
         a = longint'(dvd);
         b = longint'(dsr);
         if (sg && a >= minv) a = a - (mask + 1);
         if (sg && b >= minv) b = b - (mask + 1);
         if (sg && a == -minv && b == -1) begin
            q  = 16'(minv);
            r  = 16'h0;
            ov = 1'b1;
         end else begin
            q = 16'((a / b) & mask);
            r = 16'((a % b) & mask);
         end
      end
   endfunction

   task automatic drive(input logic v, input logic [15:0] dvd, input logic [15:0] dsr,
                        input logic sg, input logic [3:0] tg);
      if (sel == 0) begin
         a_in_valid = v; a_dividend = dvd[7:0]; a_divisor = dsr[7:0]; a_sign = sg; a_in_tag = tg;
      end else begin
         b_in_valid = v; b_dividend = dvd; b_divisor = dsr; b_sign = sg; b_in_tag = tg;
      end
   endtask

   task automatic set_ordy(input logic v);
      if (sel == 0) a_out_ready = v;
      else          b_out_ready = v;
   endtask

   task automatic check_result(input string name, input logic [15:0] eq, input logic [15:0] er,
                               input logic edz, input logic eov, input logic [3:0] etg);
      chk({name, " quotient"},    32'(cur_q),   32'(eq));
      chk({name, " remainder"},   32'(cur_r),   32'(er));
      chk({name, " div_by_zero"}, 32'(cur_dz),  32'(edz));
      chk({name, " overflow"},    32'(cur_ov),  32'(eov));
      chk({name, " out_tag"},     32'(cur_tag), 32'(etg));
   endtask

   task automatic run_op(input string name, input logic [15:0] dvd, input logic [15:0] dsr,
                         input logic sg, input logic [3:0] tg, input int hold,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input logic eov, input int elat);
      int waited;
      int lat;
      waited = 0;
      @(negedge clk);
      while (!cur_in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!cur_in_ready) begin
         chk({name, " in_ready wait"}, 32'(cur_in_ready), 32'd1);
         return;
      end
      drive(1'b1, dvd, dsr, sg, tg);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
      lat = 1;
      while (!cur_out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, 32'(lat), 32'(elat));
      if (!cur_out_valid) return;
      check_result(name, eq, er, edz, eov, tg);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, " held out_valid"}, 32'(cur_out_valid), 32'd1);
         chk({name, " held in_ready"},  32'(cur_in_ready),  32'd0);
         check_result({name, " held"}, eq, er, edz, eov, tg);
      end
      set_ordy(1'b1);
      @(negedge clk);
      set_ordy(1'b0);
      chk({name, " post out_valid"}, 32'(cur_out_valid), 32'd0);
      chk({name, " post in_ready"},  32'(cur_in_ready),  32'd1);
   endtask

   typedef struct {
      int          sel;
      logic [15:0] dvd;
      logic [15:0] dsr;
      logic        sg;
      logic [3:0]  tg;
      logic [15:0] eq;
      logic [15:0] er;
      logic        edz;
      logic        eov;
      int          elat;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen_valid;
      reset = 1'b1;
      a_in_valid = 0; a_dividend = 0; a_divisor = 0; a_sign = 0; a_in_tag = 0; a_out_ready = 0;
      b_in_valid = 0; b_dividend = 0; b_divisor = 0; b_sign = 0; b_in_tag = 0; b_out_ready = 0;

      vecs[0] = '{0, 16'd100,   16'd7,     1'b0, 4'd3,  16'd14,    16'd2,    1'b0, 1'b0, 10};
      vecs[1] = '{0, 16'h00F9,  16'h0002,  1'b1, 4'd5,  16'h00FD,  16'h00FF, 1'b0, 1'b0, 10};
      vecs[2] = '{0, 16'h0007,  16'h00FE,  1'b1, 4'd6,  16'h00FD,  16'h0001, 1'b0, 1'b0, 10};
      vecs[3] = '{0, 16'h0080,  16'h00FF,  1'b1, 4'd7,  16'h0080,  16'h0000, 1'b0, 1'b1, 10};
      vecs[4] = '{0, 16'h0080,  16'h00FF,  1'b0, 4'd8,  16'h0000,  16'h0080, 1'b0, 1'b0, 10};
      vecs[5] = '{0, 16'd5,     16'd0,     1'b0, 4'd9,  16'h00FF,  16'h0005, 1'b1, 1'b0, 1};
      vecs[6] = '{0, 16'h00F9,  16'h0000,  1'b1, 4'hA,  16'h00FF,  16'h00F9, 1'b1, 1'b0, 1};
      vecs[7] = '{0, 16'h00FF,  16'h0001,  1'b0, 4'hD,  16'h00FF,  16'h0000, 1'b0, 1'b0, 10};
      vecs[8] = '{1, 16'hFFFF,  16'h00FF,  1'b0, 4'hB,  16'd257,   16'd0,    1'b0, 1'b0, 10};
      vecs[9] = '{1, 16'h8000,  16'hFFFF,  1'b1, 4'hC,  16'h8000,  16'h0000, 1'b0, 1'b1, 10};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset a in_ready", 32'(a_in_ready), 32'd0);
      chk("reset b in_ready", 32'(b_in_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("reset a out_valid", 32'(a_out_valid), 32'd0);
      chk("reset a quotient",  32'(a_quotient),  32'd0);
      chk("reset a remainder", 32'(a_remainder), 32'd0);
      chk("reset a flags",     32'({a_dz, a_ov}), 32'd0);
      chk("reset a out_tag",   32'(a_out_tag),   32'd0);
      chk("reset a in_ready after", 32'(a_in_ready), 32'd1);
      chk("reset b in_ready after", 32'(b_in_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         sel = vecs[i].sel;
         run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dsr, vecs[i].sg, vecs[i].tg, 0,
                vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].eov, vecs[i].elat);
      end

      // Backpressure: result held for 5 cycles in DONE
      sel = 0;
      run_op("backpressure", 16'd200, 16'd9, 1'b0, 4'd1, 5, 16'd22, 16'd2, 1'b0, 1'b0, 10);

      for (int n = 0; n < 60; n++) begin
         logic [15:0] mask, dvd, dsr, eq, er;
         logic sg, edz, eov;
         logic [3:0] tg;
         int w, pick;
         sel  = n % 2;
         w    = (sel == 0) ? 8 : 16;
         mask = (sel == 0) ? 16'h00FF : 16'hFFFF;
         dvd  = 16'($urandom) & mask;
         pick = $urandom_range(0, 9);
         if (pick == 0)      dsr = 16'h0;
         else if (pick == 1) dsr = mask;
         else if (pick == 2) begin dvd = (mask >> 1) + 16'd1; dsr = mask; end
         else if (pick == 3) dsr = 16'($urandom_range(1, 3));
         else                dsr = 16'($urandom) & mask;
         sg = 1'($urandom_range(0, 1));
         tg = 4'($urandom_range(0, 15));
         ref_div(w, dvd, dsr, sg, eq, er, edz, eov);
         run_op($sformatf("rand%0d", n), dvd, dsr, sg, tg, $urandom_range(0, 2), eq, er, edz, eov,
                edz ? 1 : (w / (sel == 0 ? 1 : 2)) + 2);
      end

      // Reset pulsed mid-CALC on the 16-bit instance
      sel = 1;
      @(negedge clk);
      drive(1'b1, 16'd1000, 16'd3, 1'b0, 4'd2);
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 4'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset in_ready during reset", 32'(b_in_ready), 32'd0);
      chk("midreset out_valid during reset", 32'(b_out_valid), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("midreset in_ready after", 32'(b_in_ready), 32'd1);
      chk("midreset quotient cleared", 32'(b_quotient), 32'd0);
      seen_valid = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (b_out_valid) seen_valid++;
      end
      chk("midreset no out_valid", 32'(seen_valid), 32'd0);
      run_op("after reset", 16'd1000, 16'd3, 1'b0, 4'd4, 0, 16'd333, 16'd1, 1'b0, 1'b0, 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
